// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: pipelined imem requests, DEPTH-entry in-order queue, redirect flush.
// Optional same-cycle bypass of a kept response to decode when IFETCH_BYPASS_EN is defined.
`ifndef PC_INIT
`define PC_INIT 64'h0000_0000_8000_0000
`endif

module ifetch_queue #(
    parameter int              XLEN    = 64,
    parameter int              DEPTH   = 4,
    parameter logic [XLEN-1:0] PC_INIT = `PC_INIT
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    input  logic            branch_i,
    input  logic [XLEN-1:0] new_pc_i,
    input  logic            inst_ready_i,
    output logic            inst_valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [31:0]     inst_o
);

    localparam int              AW      = $clog2(DEPTH);
    localparam int              CW      = AW + 1;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   outs;
    logic [CW-1:0]   drop;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [31:0]     inst_mem [DEPTH];

    logic [CW:0]     credit_used;
    logic [XLEN-1:0] redirect_pc;
    logic            issue;
    logic            keep;
    logic            discard;
    logic            push;
    logic            pop;

    assign imem_addr_o = fetch_pc;
    assign credit_used = {1'b0, cnt} + {1'b0, outs};
    assign redirect_pc = new_pc_i & ~XLEN'(3);

    // Handshakes: imem request fires on imem_req_o && imem_gnt_i; decode transfer fires on
    // inst_valid_o && inst_ready_i. Valid never depends on ready; branch_i masks both valids.
    always_comb begin
        imem_req_o   = !reset && !branch_i && (credit_used < (CW+1)'(DEPTH));
        issue        = imem_req_o && imem_gnt_i;
        keep         = imem_rvalid_i && !branch_i && (drop == '0);
        discard      = imem_rvalid_i && !branch_i && (drop != '0);
        push         = keep;
        inst_valid_o = !reset && !branch_i && (cnt != '0);
        pc_o         = pc_mem[rd_ptr];
        inst_o       = inst_mem[rd_ptr];
`ifdef IFETCH_BYPASS_EN
        if (!reset && keep && (cnt == '0)) begin
            inst_valid_o = 1'b1;
            pc_o         = resp_pc;
            inst_o       = imem_rdata_i;
            push         = !inst_ready_i;
        end
        pop = inst_valid_o && inst_ready_i && (cnt != '0);
`else
        pop = inst_valid_o && inst_ready_i;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= PC_INIT;
            resp_pc  <= PC_INIT;
            cnt      <= '0;
            outs     <= '0;
            drop     <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (branch_i) begin
            // Everything still in flight is stale, including a response landing this cycle.
            fetch_pc <= redirect_pc;
            resp_pc  <= redirect_pc;
            cnt      <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            outs     <= outs - CW'(imem_rvalid_i);
            drop     <= outs - CW'(imem_rvalid_i);
        end else begin
            if (issue) fetch_pc <= fetch_pc + PC_STEP;
            if (keep) resp_pc <= resp_pc + PC_STEP;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (discard) drop <= drop - CW'(1);
            cnt  <= cnt + CW'(push) - CW'(pop);
            outs <= outs + CW'(issue) - CW'(imem_rvalid_i);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push) begin
            pc_mem[wr_ptr]   <= resp_pc;
            inst_mem[wr_ptr] <= imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: in-order memory model, expected-delivery queue and a delivery monitor.
module tb_ifetch_queue;

    localparam int          XLEN = 64;
    localparam int          W    = XLEN + 32;
    localparam logic [63:0] PC0  = 64'h0000_0000_8000_0000;

    logic            clock;
    logic            reset;
    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_gnt_i;
    logic            imem_rvalid_i;
    logic [31:0]     imem_rdata_i;
    logic            branch_i;
    logic [XLEN-1:0] new_pc_i;
    logic            inst_ready_i;
    logic            inst_valid_o;
    logic [XLEN-1:0] pc_o;
    logic [31:0]     inst_o;

    ifetch_queue #(.XLEN(XLEN), .DEPTH(4), .PC_INIT(PC0)) dut (
        .clock(clock), .reset(reset),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .branch_i(branch_i), .new_pc_i(new_pc_i),
        .inst_ready_i(inst_ready_i), .inst_valid_o(inst_valid_o),
        .pc_o(pc_o), .inst_o(inst_o)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0]    exp_q[$];
    logic [XLEN-1:0] gnt_log[$];
    int deliv_cnt = 0;
    int first_cyc = 0;
    int last_cyc  = 0;

    // memory model knobs
    int   lat         = 1;
    logic gnt_en      = 1'b1;
    logic gnt_rnd     = 1'b1;
    logic gnt_rand_en = 1'b0;
    logic rv_rand     = 1'b0;
    logic [XLEN-1:0] pend_addr[$];
    int              pend_due[$];

    assign imem_gnt_i = gnt_en & gnt_rnd;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // In-order memory: responses no earlier than lat cycles after grant, optional random stalls.
    always @(negedge clock) begin
        int due;
        if (reset) begin
            pend_addr.delete();
            pend_due.delete();
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'h0;
        end else if (pend_addr.size() != 0 && pend_due[0] <= cyc &&
                     (!rv_rand || $urandom_range(0, 3) != 0)) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(pend_addr.pop_front());
            due = pend_due.pop_front();
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
        end
        gnt_rnd = gnt_rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (!reset && imem_req_o && imem_gnt_i) begin
            pend_addr.push_back(imem_addr_o);
            pend_due.push_back(cyc + lat);
            gnt_log.push_back(imem_addr_o);
        end
    end

    // scoreboard monitor
    always @(negedge clock) begin
        logic [W-1:0] e;
        #1;
        if (!reset && inst_valid_o && inst_ready_i) begin
            deliv_cnt++;
            if (deliv_cnt == 1) first_cyc = cyc;
            last_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_delivery actual pc=%h inst=%h expected nothing", pc_o, inst_o);
            end else begin
                e = exp_q.pop_front();
                check("delivery", {pc_o, inst_o}, e);
            end
        end
    end

    // driver tasks
    task automatic push_seq(input logic [63:0] start, input int n);
        logic [63:0] p;
        p = start & ~64'h3;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({p, mem_word(p)});
            p = p + 64'd4;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset        = 1'b1;
        branch_i     = 1'b0;
        inst_ready_i = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clock);
        #2;
        check("reset_req", W'(imem_req_o), W'(0));
        check("reset_valid", W'(inst_valid_o), W'(0));
        @(negedge clock);
        reset = 1'b0;
        gnt_log.delete();
        deliv_cnt = 0;
        #2;
        check("first_req", W'(imem_req_o), W'(1));
        check("first_addr", W'(imem_addr_o), W'(PC0));
    endtask

    task automatic run_until_empty(input int max_cyc, input bit rnd_ready);
        int n;
        n = 0;
        forever begin
            @(negedge clock);
            if (exp_q.size() == 0 || n >= max_cyc) begin
                inst_ready_i = 1'b0;
                break;
            end
            inst_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            n++;
        end
        check("drain_timeout_left", W'(exp_q.size()), W'(0));
        exp_q.delete();
    endtask

    // stimulus
    initial begin
        logic [63:0] tgt[4];
        tgt = '{64'h0000_0000_8000_2000, 64'hFFFF_FFFF_FFFF_FFF8,
                64'h0000_0000_0000_1237, 64'h0000_0000_4000_0FF0};
        reset = 1'b1; branch_i = 1'b0; new_pc_i = '0; inst_ready_i = 1'b0;
        imem_rvalid_i = 1'b0; imem_rdata_i = '0;

        // streaming, ready high, 1-cycle memory
        lat = 1; gnt_rand_en = 1'b0; rv_rand = 1'b0;
        do_reset();
        push_seq(PC0, 12);
        @(negedge clock);
        inst_ready_i = 1'b1;
        #2;
`ifdef IFETCH_BYPASS_EN
        check("bypass_valid_c2", W'(inst_valid_o), W'(1));
        check("bypass_pc_c2", W'(pc_o), W'(PC0));
`else
        check("no_bypass_valid_c2", W'(inst_valid_o), W'(0));
        @(negedge clock);
        #2;
        check("queued_valid_c3", W'(inst_valid_o), W'(1));
        check("queued_pc_c3", W'(pc_o), W'(PC0));
`endif
        run_until_empty(60, 1'b0);
        check("stream_count", W'(deliv_cnt), W'(12));
        check("stream_gapless", W'(last_cyc - first_cyc), W'(11));

        // decode stalled: credit limit
        do_reset();
        repeat (9) @(negedge clock);
        #2;
        check("stall_grants", W'(gnt_log.size()), W'(4));
        check("stall_req_low", W'(imem_req_o), W'(0));
        check("stall_head_valid", W'(inst_valid_o), W'(1));
        check("stall_head", {pc_o, inst_o}, {PC0, mem_word(PC0)});
        push_seq(PC0, 4);
        run_until_empty(40, 1'b0);
        check("resume_addr", W'(gnt_log.size() >= 5 ? gnt_log[4] : 64'h0), W'(PC0 + 64'h10));

        // redirect with 3 outstanding, 3-cycle memory; first stale response lands with branch
        lat = 3;
        do_reset();
        repeat (3) @(negedge clock);
        branch_i = 1'b1;
        new_pc_i = 64'h0000_0000_8000_1002;
        exp_q.delete();
        push_seq(64'h0000_0000_8000_1000, 4);
        #2;
        check("redir3_valid", W'(inst_valid_o), W'(0));
        check("redir3_req", W'(imem_req_o), W'(0));
        @(negedge clock);
        branch_i = 1'b0;
        #2;
        check("redir3_next_req", W'(imem_req_o), W'(1));
        check("redir3_next_addr", W'(imem_addr_o), W'(64'h0000_0000_8000_1000));
        run_until_empty(60, 1'b0);

        // redirect while the queue holds an entry and a response arrives
        lat = 2;
        do_reset();
        repeat (3) @(negedge clock);
        branch_i = 1'b1;
        new_pc_i = 64'h0000_0000_9000_0000;
        exp_q.delete();
        push_seq(64'h0000_0000_9000_0000, 4);
        #2;
        check("redir_rv_valid", W'(inst_valid_o), W'(0));
        @(negedge clock);
        branch_i = 1'b0;
        #2;
        check("redir_rv_next_addr", W'(imem_addr_o), W'(64'h0000_0000_9000_0000));
        run_until_empty(60, 1'b0);

        // random stalls plus redirects, including address wrap
        lat = 2; gnt_rand_en = 1'b1; rv_rand = 1'b1;
        do_reset();
        push_seq(PC0, 40);
        for (int s = 0; s < 4; s++) begin
            int n;
            n = $urandom_range(12, 30);
            repeat (n) begin
                @(negedge clock);
                inst_ready_i = 1'($urandom_range(0, 1));
            end
            @(negedge clock);
            branch_i     = 1'b1;
            new_pc_i     = tgt[s];
            inst_ready_i = 1'($urandom_range(0, 1));
            exp_q.delete();
            push_seq(tgt[s], 40);
            @(negedge clock);
            branch_i     = 1'b0;
            inst_ready_i = 1'($urandom_range(0, 1));
        end
        run_until_empty(800, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Parametrised instruction-fetch front end with a pipelined memory request/response interface, a DEPTH-entry in-order fetch queue and valid/ready delivery to decode. It replaces the single-register PC + 4 fetch stage: requests are issued ahead of decode, up to DEPTH in flight or buffered. A redirect from decode flushes the queue and drops stale responses. It sits between the instruction memory port and the id stage.

## Interface
Parameters:
- XLEN, 64, PC and address width.
- DEPTH, 4, queue entries and maximum in-flight plus buffered fetches; power of two, at least 2.
- PC_INIT, `PC_INIT, fetch PC loaded on reset.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  XLEN  fetch address, always equal to fetch_pc.
- imem_gnt_i  in  1  memory accepts the request this cycle.
- imem_rvalid_i  in  1  response valid; responses return in order, at least 1 cycle after grant; no backpressure.
- imem_rdata_i  in  32  response instruction word.
- branch_i  in  1  redirect from id.
- new_pc_i  in  XLEN  redirect target; bits [1:0] are forced to 0.
- inst_ready_i  in  1  decode accepts the presented instruction.
- inst_valid_o  out  1  instruction valid.
- pc_o  out  XLEN  PC of the presented instruction.
- inst_o  out  32  presented instruction.

## Operation
- State:
  - fetch_pc: next address to request.
  - resp_pc: PC of the next kept response.
  - cnt: queue occupancy.
  - outs: requests granted but not yet answered, including ones that will be dropped.
  - drop: responses still to discard.
  - All counters are clog2(DEPTH)+1 bits wide.
- Request:
  - imem_req_o = !reset && !branch_i && (cnt + outs < DEPTH).
  - A request is issued when imem_req_o && imem_gnt_i; then fetch_pc <= fetch_pc + 4, wrapping modulo 2^XLEN.
- Response is kept when imem_rvalid_i && !branch_i && drop == 0.
  - A kept response pushes {resp_pc, imem_rdata_i} and sets resp_pc <= resp_pc + 4.
  - A response arriving when drop != 0 is discarded and drop decrements.
- outs_next = outs + issue − imem_rvalid_i.
- Pop occurs when inst_valid_o && inst_ready_i.
- cnt_next = cnt + push − pop.
- The credit rule cnt + outs ≤ DEPTH guarantees no overflow; a kept response is never refused.
- inst_valid_o = (cnt != 0) && !branch_i; pc_o and inst_o come from the queue head.
- Redirect (branch_i = 1), taking priority over everything:
  - The queue is flushed (cnt <= 0).
  - fetch_pc <= resp_pc <= {new_pc_i[XLEN-1:2], 2'b00}.
  - drop <= outs − imem_rvalid_i; a response arriving in the redirect cycle is discarded.
  - No pop and no issue happen in that cycle.

## Timing
- Reset values:
  - inst_valid_o = 0, imem_req_o = 0 (during reset).
  - fetch_pc = resp_pc = PC_INIT.
  - cnt = outs = drop = 0.
  - pc_o and inst_o are don't-care while inst_valid_o = 0.
- The first request is issued in the cycle after reset deasserts, at PC_INIT.
- Latency from response to inst_valid_o is 1 cycle (registered queue), unless bypass is enabled.
- After a redirect in cycle N, the first request at new_pc_i is issued in cycle N+1.
- Full condition: cnt + outs == DEPTH deasserts imem_req_o in the same cycle, combinationally. A pop in that cycle frees credit only from the next cycle.
- Empty queue with no response: inst_valid_o = 0.
- Reset asserted mid-operation overrides redirect and all pending state in the next cycle. Memory must also be reset, because outstanding responses are not tracked across reset.

## Configuration
- IFETCH_BYPASS_EN:
  - Defined: when cnt == 0 and a response is kept, inst_valid_o = 1 in the same cycle, with pc_o = resp_pc and inst_o = imem_rdata_i.
    - If inst_ready_i = 1, the word is consumed without being pushed.
    - Otherwise it is pushed as usual.
    - Combinational path from imem_rvalid_i/imem_rdata_i to the outputs.
  - Undefined: every instruction passes through the queue, giving 1 cycle minimum latency and no combinational path from the memory inputs to the outputs.

## Test plan
- Reset, PC_INIT = 0x80000000, memory grants every cycle with 1-cycle response latency, inst_ready_i = 1 -> pc_o sequence 0x80000000, 0x80000004, … with no gaps after fill; cnt + outs never exceeds 4.
- inst_ready_i = 0 held with DEPTH = 4 -> exactly 4 requests issued, then imem_req_o = 0. Releasing ready -> 4 instructions in order, then requests resume at 0x80000010.
- Memory response latency of 3 cycles with 3 outstanding, then branch_i with new_pc_i = 0x80001002 -> the 3 stale responses are discarded, the next request is at 0x80001000, and the first delivered pc_o is 0x80001000.
- branch_i in the same cycle as imem_rvalid_i -> that response is discarded, drop = outs − 1, and inst_valid_o = 0 in that cycle.
- Random gnt/rvalid/ready stalls and redirects against a reference PC model -> every delivered pc_o/inst_o pair matches memory contents; no loss, duplication or overflow.
- With IFETCH_BYPASS_EN, empty queue, response with ready = 1 -> inst_valid_o in the same cycle and cnt remains 0. Without the macro -> inst_valid_o one cycle later.
